hf_pair_writer: RTL and testbench
=================================

HF_PAIR_WRITER -- requirements
Module: hf_pair_writer

Interface
REQ-001 The block SHALL use clock clk and reset rst, where rst is synchronous and active-high.
REQ-002 Port `clk`: input, 1 bit, rising-edge clock.
REQ-003 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 Port `start`: input, 1 bit, one-cycle pulse that begins a granule; honoured only in IDLE.
REQ-005 Port `big_values`: input, 9 bits, number of Huffman pairs in the granule; sampled on `start`.
REQ-006 Port `pair_valid`: input, 1 bit, one-cycle strobe from the Huffman table decoder.
REQ-007 Port `x_val`: input, 16 bits signed, decoded x sample; qualified by `pair_valid`.
REQ-008 Port `y_val`: input, 16 bits signed, decoded y sample; qualified by `pair_valid`.
REQ-009 Port `pair_ready`: output, 1 bit, high when a pair strobed this cycle will be accepted; used to gate the upstream bit feed.
REQ-010 Port `wr_en`: output, 1 bit, sample-memory write strobe.
REQ-011 Port `wr_addr`: output, 10 bits, sample index in the range 0..575.
REQ-012 Port `wr_data`: output, 16 bits signed, sample value.
REQ-013 Port `busy`: output, 1 bit, high while a granule is in progress.
REQ-014 Port `done`: output, 1 bit, one-cycle pulse at granule end.
REQ-015 Port `err`: output, 1 bit, sticky flag for a dropped pair; cleared on `start`.

Function
REQ-016 The block SHALL implement states IDLE, RUN, FILL and FINISH.
REQ-017 IDLE: on `start`, the block SHALL latch target = min(`big_values`, 288), clear the pair counters, write address and `err`, and go to RUN next cycle.
REQ-018 `start` in any state other than IDLE SHALL be ignored.
REQ-019 RUN: the block SHALL provide a 4-entry pair FIFO; push and pop in the same cycle SHALL be supported.
REQ-020 `pair_ready` SHALL be high only when state = RUN, FIFO occupancy < 4 and accepted pairs < target.
REQ-021 A `pair_valid` while `pair_ready` = 0 and `busy` = 1 SHALL be dropped and SHALL set `err`.
REQ-022 A `pair_valid` in IDLE SHALL be ignored and SHALL NOT set `err`.
REQ-023 Drain: the FIFO head SHALL write x to address 2k, then y to address 2k+1 on the following cycle, then pop; k is the count of pairs written.
REQ-024 Throughput SHALL be 1 sample per cycle and 1 pair per 2 cycles.
REQ-025 `wr_en`, `wr_addr` and `wr_data` SHALL be registered.
REQ-026 A pair accepted at cycle N into an empty FIFO while the drain is idle SHALL produce its x write at N+1 and its y write at N+2.
REQ-027 When pairs written = target and the FIFO is empty, the block SHALL go to FILL (macro defined) or FINISH (macro undefined); this includes target = 0.
REQ-028 FILL: the block SHALL write `wr_data` = 0 once per cycle at consecutive addresses from 2*target through 575, then go to FINISH.
REQ-029 With target = 288, FILL SHALL perform zero writes.
REQ-030 FINISH: the block SHALL pulse `done` for one cycle, return to IDLE, and assert `busy` = 0 from the next cycle.
REQ-031 `busy` SHALL be high in RUN, FILL and FINISH.
REQ-032 `wr_addr` SHALL never exceed 575 and SHALL never wrap.
REQ-033 `wr_en` SHALL never assert in IDLE.

Reset
REQ-034 On `rst`, the block SHALL set state to IDLE, empty the FIFO, and zero all counters, the address and the target.
REQ-035 On `rst`, outputs SHALL be: `pair_ready` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `busy` = 0, `done` = 0, `err` = 0.
REQ-036 `rst` during RUN or FILL SHALL abort the granule with no `done` pulse and no further writes; the next `start` SHALL operate normally.

Configuration
REQ-037 When macro HF_ZERO_FILL_EN is defined, FILL SHALL be built and every granule SHALL write exactly 576 samples, addresses 0..575, before `done`.
REQ-038 When HF_ZERO_FILL_EN is undefined, FILL SHALL NOT exist, exactly 2*target samples SHALL be written, and the count1/zero region is owned downstream.

Verification
REQ-039 `big_values` = 2; pairs (3,-5) then (0,7), spaced 5 cycles -> writes addr0 = 3, addr1 = -5, addr2 = 0, addr3 = 7; with macro, zeros at addr4..575, then `done`; `err` = 0.
REQ-040 `big_values` = 6; `pair_valid` held every cycle that `pair_ready` = 1 -> 12 writes at addr0..11 in order; `err` = 0.
REQ-041 `big_values` = 20; 10 consecutive `pair_valid` cycles ignoring `pair_ready` -> `err` = 1; dropped pairs are never written; accepted pairs are written at consecutive addresses.
REQ-042 `big_values` = 400 -> target clamped to 288; last pair written at addr574/575; no FILL writes; `done` follows.
REQ-043 `big_values` = 0 -> with macro, 576 zero writes; without macro, `done` at start+2 and no writes.
REQ-044 `rst` in RUN after 3 pairs -> all outputs 0 next cycle, no `done`; a new `start` with `big_values` = 1 writes addr0/1 correctly.

Source files
------------

// File: rtl/hf_pair_writer.sv
// Huffman pair writer: queues decoded (x,y) pairs and streams them to sample memory.
// Optional zero fill of the tail region is built when HF_ZERO_FILL_EN is defined.
module hf_pair_writer (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8:0]         big_values,
  input  logic               pair_valid,
  input  logic signed [15:0] x_val,
  input  logic signed [15:0] y_val,
  output logic               pair_ready,
  output logic               wr_en,
  output logic [9:0]         wr_addr,
  output logic signed [15:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FILL,
    FINISH
  } state_t;

  state_t state, state_nx;

  logic [8:0] target;
  logic [8:0] accepted;
  logic [8:0] written;
  logic [2:0] count;
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic       phase;

  logic signed [15:0] fx [4];
  logic signed [15:0] fy [4];

  logic               push;
  logic               pop;
  logic               have;
  logic               run_done;
  logic signed [15:0] head_x;
  logic signed [15:0] head_y;

`ifdef HF_ZERO_FILL_EN
  logic [9:0] fill_ptr;
`endif

  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);
  assign pair_ready = (state == RUN) && (count < 3'd4)
                      && (accepted < target);
  assign push       = pair_valid && pair_ready;
  // phase=1 means the head's x is out and its y goes next
  assign pop        = (state == RUN) && phase;
  assign have       = (count != 3'd0) || push;
  assign head_x     = (count == 3'd0) ? x_val : fx[rd_ptr];
  assign head_y     = fy[rd_ptr];
  assign run_done   = (written == target) && (count == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        if (run_done) begin
`ifdef HF_ZERO_FILL_EN
          state_nx = FILL;
`else
          state_nx = FINISH;
`endif
        end
      end
`ifdef HF_ZERO_FILL_EN
      FILL: begin
        if (fill_ptr >= 10'd575) state_nx = FINISH;
      end
`endif
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fx[wr_ptr] <= x_val;
      fy[wr_ptr] <= y_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target   <= '0;
      accepted <= '0;
      written  <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      phase    <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
`ifdef HF_ZERO_FILL_EN
      fill_ptr <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (pair_valid && !pair_ready && busy) err <= 1'b1;
      if (state == IDLE && start) begin
        target   <= (big_values > 9'd288) ? 9'd288 : big_values;
        accepted <= '0;
        written  <= '0;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        phase    <= 1'b0;
        wr_addr  <= '0;
        err      <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + 2'd1;
          accepted <= accepted + 9'd1;
        end
        if (state == RUN && have) begin
          wr_en   <= 1'b1;
          wr_addr <= {written, phase};
          wr_data <= phase ? head_y : head_x;
          phase   <= ~phase;
          if (phase) begin
            rd_ptr  <= rd_ptr + 2'd1;
            written <= written + 9'd1;
          end
        end
        count <= count + {2'b0, push} - {2'b0, pop};
`ifdef HF_ZERO_FILL_EN
        if (state == RUN && run_done) fill_ptr <= {target, 1'b0};
        if (state == FILL && fill_ptr < 10'd576) begin
          wr_en    <= 1'b1;
          wr_addr  <= fill_ptr;
          wr_data  <= '0;
          fill_ptr <= fill_ptr + 10'd1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_hf_pair_writer.sv
// Directed bench for hf_pair_writer; write log compared against hand-built expectations.
// Expectations follow HF_ZERO_FILL_EN when the bench is built with it.
module tb_hf_pair_writer;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [8:0]         big_values;
  logic               pair_valid;
  logic signed [15:0] x_val;
  logic signed [15:0] y_val;
  logic               pair_ready;
  logic               wr_en;
  logic [9:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic               busy;
  logic               done;
  logic               err;

  hf_pair_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .big_values (big_values),
    .pair_valid (pair_valid),
    .x_val      (x_val),
    .y_val      (y_val),
    .pair_ready (pair_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int idle_wr = 0;
  int bad_addr = 0;

  logic [9:0]         log_a [$];
  logic signed [15:0] log_d [$];
  int                 log_c [$];
  logic signed [15:0] exp_d [$];

  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      log_a.push_back(wr_addr);
      log_d.push_back(wr_data);
      log_c.push_back(cyc);
      if (!busy) idle_wr++;
      if (wr_addr > 10'd575) bad_addr++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(string tag, longint obs, longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_a.delete();
    log_d.delete();
    log_c.delete();
    exp_d.delete();
  endtask

  task automatic do_start(int bv);
    start      = 1'b1;
    big_values = 9'(bv);
    tick();
    start      = 1'b0;
  endtask

  task automatic send_pair(int xv, int yv);
    int n = 0;
    while (!pair_ready && n < 50) begin
      tick();
      n++;
    end
    chk("feed_ready", pair_ready, 1);
    pair_valid = 1'b1;
    x_val      = 16'(xv);
    y_val      = 16'(yv);
    exp_d.push_back(16'(xv));
    exp_d.push_back(16'(yv));
    tick();
    pair_valid = 1'b0;
  endtask

  task automatic wait_done(string tag, int limit);
    int n  = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < limit) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done_cnt - d0, 1);
    tick();
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic check_log(string tag);
    int bad = 0;
`ifdef HF_ZERO_FILL_EN
    while (exp_d.size() < 576) exp_d.push_back(16'sd0);
`endif
    chk({tag, "_nwr"}, log_a.size(), exp_d.size());
    for (int i = 0; i < log_a.size() && i < exp_d.size(); i++)
      if (log_a[i] !== 10'(i) || log_d[i] !== exp_d[i]) bad++;
    chk({tag, "_data"}, bad, 0);
  endtask

  initial begin
    int k;
    int n;
    int sent;
    int d0;
    int l0;
    rst        = 1'b1;
    start      = 1'b0;
    big_values = '0;
    pair_valid = 1'b0;
    x_val      = '0;
    y_val      = '0;
    tick(3);
    chk("reset_outs",
        {pair_ready, wr_en, wr_addr, wr_data, busy, done, err}, 0);
    rst = 1'b0;
    tick();

    // pair_valid while idle is ignored
    pair_valid = 1'b1;
    x_val      = 16'sd1;
    tick();
    pair_valid = 1'b0;
    tick();
    chk("idle_valid_err", err, 0);
    chk("idle_valid_wr", log_a.size(), 0);

    // two spaced pairs, plus a start pulse mid-granule that must be ignored
    clear_logs();
    do_start(2);
    k = cyc;
    send_pair(3, -5);
    tick(2);
    start      = 1'b1;
    big_values = 9'd0;
    tick();
    start      = 1'b0;
    tick();
    send_pair(0, 7);
    wait_done("bv2", 1000);
    check_log("bv2");
    chk("bv2_lat_x", log_c.size() > 0 ? log_c[0] : -1, k + 2);
    chk("bv2_lat_y", log_c.size() > 1 ? log_c[1] : -1, k + 3);
    chk("bv2_err", err, 0);

    // back-to-back handshake
    clear_logs();
    do_start(6);
    sent = 0;
    n    = 0;
    while (sent < 6 && n < 100) begin
      pair_valid = pair_ready;
      x_val      = 16'(10 * sent + 1);
      y_val      = 16'(-(10 * sent + 2));
      if (pair_ready) begin
        exp_d.push_back(16'(10 * sent + 1));
        exp_d.push_back(16'(-(10 * sent + 2)));
        sent++;
      end
      tick();
      n++;
    end
    pair_valid = 1'b0;
    wait_done("bv6", 200);
    check_log("bv6");
    chk("bv6_err", err, 0);

    // 10-cycle burst ignoring pair_ready: burst slots 7 and 9 hit a full FIFO
    clear_logs();
    do_start(20);
    for (int i = 0; i < 10; i++) begin
      pair_valid = 1'b1;
      x_val      = 16'(100 + i);
      y_val      = 16'(-100 - i);
      if (i != 7 && i != 9) begin
        exp_d.push_back(16'(100 + i));
        exp_d.push_back(16'(-100 - i));
      end
      tick();
    end
    pair_valid = 1'b0;
    chk("burst_err", err, 1);
    for (int j = 0; j < 12; j++) send_pair(200 + j, -200 - j);
    wait_done("bv20", 1000);
    check_log("bv20");
    chk("bv20_err_sticky", err, 1);

    // clamp to 288 pairs
    clear_logs();
    do_start(400);
    for (int j = 0; j < 288; j++) send_pair(j, -j - 1);
    wait_done("bv400", 2000);
    check_log("bv400");
    chk("bv400_last_addr", log_a.size() > 0 ? log_a[log_a.size() - 1] : -1,
        575);
    chk("bv400_err", err, 0);

    // empty granule
    clear_logs();
    k = cyc;
    do_start(0);
    wait_done("bv0", 1000);
    check_log("bv0");
`ifndef HF_ZERO_FILL_EN
    chk("bv0_done_cyc", done_cyc, k + 3);
`endif

    // abort in RUN after 3 pairs
    clear_logs();
    do_start(10);
    for (int j = 0; j < 3; j++) send_pair(50 + j, -50 - j);
    n = 0;
    while (log_a.size() < 6 && n < 50) begin
      tick();
      n++;
    end
    chk("abort_pre_wr", log_a.size(), 6);
    rst = 1'b1;
    tick();
    chk("abort_outs",
        {pair_ready, wr_en, wr_addr, wr_data, busy, done, err}, 0);
    rst = 1'b0;
    d0  = done_cnt;
    l0  = log_a.size();
    tick(20);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_wr", log_a.size() - l0, 0);
    clear_logs();
    do_start(1);
    send_pair(9, -9);
    wait_done("post_abort", 1000);
    check_log("post_abort");

    chk("no_idle_writes", idle_wr, 0);
    chk("addr_in_range", bad_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
